// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
//  pc_state_e     : RUN / SLEEP state of the WFI sleep FSM
//  redirect_src_e : which source drives the next PC in a given cycle
//  PC_INST_BYTES  : default sequential increment in bytes
package pc_pkg;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_SLEEP = 1'b1
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_TRAP = 3'd1,
    SRC_FB   = 3'd2,
    SRC_EX   = 3'd3,
    SRC_PRED = 3'd4,
    SRC_SEQ  = 3'd5
  } redirect_src_e;

  localparam int unsigned PC_INST_BYTES = 32'd4;

endpackage

// File: rtl/pc_fallback_fifo.sv
// Fallback FIFO: holds the sequential PC (pc + INST_BYTES) for every taken
// prediction still awaiting resolution, oldest at the head.
//  clk, rst  : clock and asynchronous active-low reset
//  push      : enqueue push_data (ignored when full unless a pop frees a slot)
//  push_data : sequential PC to remember
//  pop       : drop the oldest entry (ignored when empty)
//  flush     : discard every entry; wins over push and pop
//  head      : oldest entry
//  full      : FB_DEPTH entries held
//  empty     : no entries held
module pc_fallback_fifo #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [XLEN-1:0] head,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_r [FB_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (count_r == CNT_W'(0));
  // FB_DEPTH is a power of two, so the count MSB alone means full.
  assign full      = count_r[PTR_W];
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FB_DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  pc_fallback_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .pop   (pop),
    .flush (flush),
    .empty (empty)
  );

endmodule

// File: rtl/pc_fallback_fifo_chk.sv
// Simulation checker for the fallback FIFO: a pop that is not masked by a
// flush must never reach an empty FIFO.
//  clk, rst : clock and asynchronous active-low reset
//  pop      : pop request seen by the FIFO
//  flush    : flush request seen by the FIFO
//  empty    : FIFO empty flag
module pc_fallback_fifo_chk (
  input logic clk,
  input logic rst,
  input logic pop,
  input logic flush,
  input logic empty
);

  // Flag a pop request that arrives while the FIFO holds nothing.
  always_ff @(posedge clk) begin
    if (rst && pop && !flush) begin
      assert (!empty) else $error("pc_fallback_fifo: pop while empty");
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator ahead of IF. Owns the PC register, a WFI sleep
// FSM, a single-entry pending-redirect latch that survives stalls, and the
// fallback FIFO that restores the sequential PC after a wrong prediction.
//  clk, rst        : clock and asynchronous active-low reset
//  stall_hazard    : hazard stall, hold PC
//  stall_cpu       : memory/bus stall, hold PC
//  trap_en/trap_pc : trap entry/return target, highest priority
//  ex_redirect/ex_pc       : EX-resolved unpredicted redirect
//  pred_taken/pred_pc      : IF prediction
//  resolve_valid/resolve_wrong : EX resolution of oldest prediction
//  wfi_enter/wake  : enter sleep / leave sleep
//  pc              : current PC
//  sleeping        : FSM is in SLEEP
//  fb_full         : fallback FIFO full, predictions suppressed
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INST_BYTES   = PC_INST_BYTES,
  parameter int unsigned     FB_DEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_hazard,
  input  logic            stall_cpu,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            resolve_valid,
  input  logic            resolve_wrong,
  input  logic            wfi_enter,
  input  logic            wake,
  output logic [XLEN-1:0] pc,
  output logic            sleeping,
  output logic            fb_full
);

  pc_state_e       state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s, pc_seq_s;
  logic            pend_valid_r, pend_valid_nxt_s;
  logic [XLEN-1:0] pend_pc_r, pend_pc_nxt_s;
  logic            pend_fb_r, pend_fb_nxt_s;   // pending entry came from a mispredict
  redirect_src_e   src_s;
  logic            use_pend_s;
  logic            fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic [XLEN-1:0] fifo_head_s;
  logic            fifo_empty_s, fifo_full_s;
  logic            stall_s, fb_hit_s;

  assign pc_seq_s = pc_r + XLEN'(INST_BYTES);
  assign stall_s  = stall_hazard | stall_cpu;
  // A wrong resolution with nothing outstanding has nothing to restore.
  assign fb_hit_s = resolve_valid & resolve_wrong & ~fifo_empty_s;

  pc_fallback_fifo #(
    .XLEN     (XLEN),
    .FB_DEPTH (FB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (pc_seq_s),
    .pop       (fifo_pop_s),
    .flush     (fifo_flush_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Per-cycle priority decision: redirect source, FSM, pending latch, FIFO controls.
  always_comb begin
    src_s            = SRC_NONE;
    use_pend_s       = 1'b0;
    state_nxt_s      = state_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_pc_nxt_s    = pend_pc_r;
    pend_fb_nxt_s    = pend_fb_r;
    fifo_push_s      = 1'b0;
    fifo_flush_s     = 1'b0;
    fifo_pop_s       = resolve_valid & ~resolve_wrong & ~trap_en;
    case (state_r)
      PC_RUN: begin
        if (trap_en) begin
          src_s            = SRC_TRAP;
          fifo_flush_s     = 1'b1;
          pend_valid_nxt_s = 1'b0;
        end else if (stall_s) begin
          // Mispredict fallback outranks an EX redirect in the latch.
          if (fb_hit_s) begin
            pend_valid_nxt_s = 1'b1;
            pend_pc_nxt_s    = fifo_head_s;
            pend_fb_nxt_s    = 1'b1;
            fifo_flush_s     = 1'b1;
          end else if (ex_redirect && !(pend_valid_r && pend_fb_r)) begin
            pend_valid_nxt_s = 1'b1;
            pend_pc_nxt_s    = ex_pc;
            pend_fb_nxt_s    = 1'b0;
            fifo_flush_s     = 1'b1;
          end else begin
            src_s = SRC_NONE;
          end
        end else if (pend_valid_r) begin
          src_s            = pend_fb_r ? SRC_FB : SRC_EX;
          use_pend_s       = 1'b1;
          pend_valid_nxt_s = 1'b0;
        end else if (fb_hit_s) begin
          src_s        = SRC_FB;
          fifo_flush_s = 1'b1;
        end else if (ex_redirect) begin
          src_s        = SRC_EX;
          fifo_flush_s = 1'b1;
        end else if (wfi_enter) begin
          state_nxt_s = PC_SLEEP;
        end else if (pred_taken && !fifo_full_s) begin
          src_s       = SRC_PRED;
          fifo_push_s = 1'b1;
        end else begin
          src_s = SRC_SEQ;
        end
      end
      PC_SLEEP: begin
        if (trap_en) begin
          src_s            = SRC_TRAP;
          state_nxt_s      = PC_RUN;
          fifo_flush_s     = 1'b1;
          pend_valid_nxt_s = 1'b0;
        end else if (wake) begin
          state_nxt_s = PC_RUN;
        end else begin
          src_s = SRC_NONE;
        end
      end
      default: begin
        state_nxt_s = PC_RUN;
      end
    endcase
  end

  // Next-PC multiplexer driven by the selected source.
  always_comb begin
    pc_nxt_s = pc_r;
    case (src_s)
      SRC_TRAP: pc_nxt_s = trap_pc;
      SRC_FB:   pc_nxt_s = use_pend_s ? pend_pc_r : fifo_head_s;
      SRC_EX:   pc_nxt_s = use_pend_s ? pend_pc_r : ex_pc;
      SRC_PRED: pc_nxt_s = pred_pc;
      SRC_SEQ:  pc_nxt_s = pc_seq_s;
      default:  pc_nxt_s = pc_r;
    endcase
  end

  // PC, FSM state and pending-redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r         <= RESET_VECTOR;
      state_r      <= PC_RUN;
      pend_valid_r <= 1'b0;
      pend_pc_r    <= '0;
      pend_fb_r    <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      state_r      <= state_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      pend_fb_r    <= pend_fb_nxt_s;
    end
  end

  assign pc       = pc_r;
  assign sleeping = (state_r == PC_SLEEP);
  assign fb_full  = fifo_full_s;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_hazard, stall_cpu, trap_en, ex_redirect, pred_taken;
  logic        resolve_valid, resolve_wrong, wfi_enter, wake;
  logic [31:0] trap_pc, ex_pc, pred_pc;
  logic [31:0] pc;
  logic        sleeping, fb_full;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0100),
    .INST_BYTES   (4),
    .FB_DEPTH     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_hazard  (stall_hazard),
    .stall_cpu     (stall_cpu),
    .trap_en       (trap_en),
    .trap_pc       (trap_pc),
    .ex_redirect   (ex_redirect),
    .ex_pc         (ex_pc),
    .pred_taken    (pred_taken),
    .pred_pc       (pred_pc),
    .resolve_valid (resolve_valid),
    .resolve_wrong (resolve_wrong),
    .wfi_enter     (wfi_enter),
    .wake          (wake),
    .pc            (pc),
    .sleeping      (sleeping),
    .fb_full       (fb_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_hazard = 1'b0; stall_cpu = 1'b0; trap_en = 1'b0; ex_redirect = 1'b0;
    pred_taken = 1'b0; resolve_valid = 1'b0; resolve_wrong = 1'b0;
    wfi_enter = 1'b0; wake = 1'b0;
    trap_pc = 32'h0; ex_pc = 32'h0; pred_pc = 32'h0;
  endtask

  task automatic trap_to(input logic [31:0] target);
    trap_en = 1'b1; trap_pc = target;
    step();
    trap_en = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    step(); step();
    check("reset_pc", pc, 32'h100);
    check("reset_sleeping", {31'd0, sleeping}, 32'd0);
    check("reset_fb_full", {31'd0, fb_full}, 32'd0);
    rst = 1'b1;
    check("release_pc", pc, 32'h100);
    step(); check("seq_1", pc, 32'h104);
    step(); check("seq_2", pc, 32'h108);

    // Prediction then mispredict two cycles later.
    trap_to(32'h10);           check("trap_0x10", pc, 32'h10);
    pred_taken = 1'b1; pred_pc = 32'h80; step(); pred_taken = 1'b0;
    check("pred_0x80", pc, 32'h80);
    step(); check("after_pred", pc, 32'h84);
    resolve_valid = 1'b1; resolve_wrong = 1'b1; step();
    check("mispredict_restore", pc, 32'h14);
    step(); check("wrong_on_empty_ignored", pc, 32'h18);
    resolve_valid = 1'b0; resolve_wrong = 1'b0;

    // EX redirect captured under a 3-cycle stall.
    stall_cpu = 1'b1; ex_redirect = 1'b1; ex_pc = 32'h200; step(); ex_redirect = 1'b0;
    check("stall_hold_1", pc, 32'h18);
    step(); check("stall_hold_2", pc, 32'h18);
    step(); check("stall_hold_3", pc, 32'h18);
    stall_cpu = 1'b0; step(); check("pending_ex_applied", pc, 32'h200);
    step(); check("after_pending", pc, 32'h204);

    // Mispredict fallback outranks EX redirect in the pending latch.
    pred_taken = 1'b1; pred_pc = 32'h300; step(); pred_taken = 1'b0;
    check("pred_0x300", pc, 32'h300);
    stall_hazard = 1'b1; resolve_valid = 1'b1; resolve_wrong = 1'b1;
    ex_redirect = 1'b1; ex_pc = 32'h500; step();
    resolve_valid = 1'b0; resolve_wrong = 1'b0; ex_pc = 32'h600; step();
    ex_redirect = 1'b0;
    check("stall_hold_fb", pc, 32'h300);
    stall_hazard = 1'b0; step(); check("pending_fb_wins", pc, 32'h208);
    step(); check("after_pending_fb", pc, 32'h20c);

    // Equal-rank pending events: the later one wins.
    stall_cpu = 1'b1; ex_redirect = 1'b1; ex_pc = 32'h700; step();
    ex_pc = 32'h710; step(); ex_redirect = 1'b0; stall_cpu = 1'b0;
    step(); check("pending_overwrite", pc, 32'h710);

    // Fill the fallback FIFO and check suppression and FIFO order.
    pred_taken = 1'b1; pred_pc = 32'h800; step();
    check("pred_a", pc, 32'h800); check("not_full_1", {31'd0, fb_full}, 32'd0);
    pred_pc = 32'h900; step();
    check("pred_b", pc, 32'h900); check("full_2", {31'd0, fb_full}, 32'd1);
    pred_pc = 32'hA00; step();
    check("pred_suppressed", pc, 32'h904); check("still_full", {31'd0, fb_full}, 32'd1);
    pred_taken = 1'b0; resolve_valid = 1'b1; step();
    check("resolve_ok_seq", pc, 32'h908); check("pop_clears_full", {31'd0, fb_full}, 32'd0);
    resolve_wrong = 1'b1; step(); resolve_valid = 1'b0; resolve_wrong = 1'b0;
    check("second_entry_restore", pc, 32'h804);

    // WFI sleep held through stalls, trap wakes.
    trap_to(32'h40);
    wfi_enter = 1'b1; step(); wfi_enter = 1'b0;
    check("wfi_pc", pc, 32'h40); check("wfi_sleeping", {31'd0, sleeping}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      stall_cpu = i[0];
      step();
      check("sleep_hold", pc, 32'h40);
    end
    stall_cpu = 1'b0;
    trap_to(32'h8);
    check("sleep_trap_pc", pc, 32'h8); check("sleep_trap_awake", {31'd0, sleeping}, 32'd0);
    step(); check("after_sleep_trap", pc, 32'hc);

    // Wake without trap keeps pc; trap with wake takes trap path.
    trap_to(32'h40);
    wfi_enter = 1'b1; step(); wfi_enter = 1'b0;
    wake = 1'b1; step(); wake = 1'b0;
    check("wake_pc", pc, 32'h40); check("wake_awake", {31'd0, sleeping}, 32'd0);
    step(); check("after_wake", pc, 32'h44);
    wfi_enter = 1'b1; step(); wfi_enter = 1'b0;
    wake = 1'b1; trap_en = 1'b1; trap_pc = 32'h60; step(); wake = 1'b0; trap_en = 1'b0;
    check("wake_and_trap", pc, 32'h60);

    // Trap overrides everything and clears FIFO and pending.
    pred_taken = 1'b1; pred_pc = 32'h900; step(); pred_taken = 1'b0;
    stall_cpu = 1'b1; ex_redirect = 1'b1; ex_pc = 32'h123; step();
    check("pending_setup_hold", pc, 32'h900);
    trap_en = 1'b1; trap_pc = 32'h20; ex_pc = 32'h300;
    resolve_valid = 1'b1; resolve_wrong = 1'b1; step();
    check("trap_all", pc, 32'h20);
    idle(); step(); check("trap_cleared_pending", pc, 32'h24);
    resolve_valid = 1'b1; resolve_wrong = 1'b1; step(); idle();
    check("trap_cleared_fifo", pc, 32'h28);

    // Asynchronous reset mid-operation leaves no residue.
    pred_taken = 1'b1; pred_pc = 32'hA0; step(); pred_taken = 1'b0;
    stall_cpu = 1'b1; ex_redirect = 1'b1; ex_pc = 32'h555; step(); idle();
    #2 rst = 1'b0;
    #1 check("async_reset_pc", pc, 32'h100);
    step(); rst = 1'b1;
    step(); check("post_reset_seq", pc, 32'h104);
    resolve_valid = 1'b1; resolve_wrong = 1'b1; step(); idle();
    check("post_reset_no_residue", pc, 32'h108);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
